// File: rtl/ppu_mem_responder_if.sv
// ppu_mem_responder_if: PPU fetch/flag, CPU and OAM-DMA signal bundle for ppu_mem_responder
interface ppu_mem_responder_if;
  logic [1:0]  mode_in;
  logic        lcd_en_in;
  logic [15:0] ppu_addr_in;
  logic        ppu_addr_valid_in;
  logic [7:0]  ppu_data_out;
  logic        ppu_data_valid_out;
  logic [15:0] flag_addr_in;
  logic        flag_addr_valid_in;
  logic [7:0]  flag_data_out;
  logic        flag_data_valid_out;
  logic [15:0] cpu_addr_in;
  logic        cpu_rd_in;
  logic        cpu_wr_in;
  logic [7:0]  cpu_wdata_in;
  logic [7:0]  cpu_rdata_out;
  logic        cpu_rdata_valid_out;
  logic        dma_start_in;
  logic [7:0]  dma_src_in;
  logic [15:0] dma_addr_out;
  logic        dma_rd_out;
  logic [7:0]  dma_data_in;
  logic        dma_data_valid_in;
  logic        dma_busy_out;
  logic        dma_done_out;
  modport slave (
    input  mode_in, lcd_en_in, ppu_addr_in, ppu_addr_valid_in, flag_addr_in, flag_addr_valid_in,
           cpu_addr_in, cpu_rd_in, cpu_wr_in, cpu_wdata_in, dma_start_in, dma_src_in,
           dma_data_in, dma_data_valid_in,
    output ppu_data_out, ppu_data_valid_out, flag_data_out, flag_data_valid_out,
           cpu_rdata_out, cpu_rdata_valid_out, dma_addr_out, dma_rd_out, dma_busy_out, dma_done_out
  );
  modport master (
    output mode_in, lcd_en_in, ppu_addr_in, ppu_addr_valid_in, flag_addr_in, flag_addr_valid_in,
           cpu_addr_in, cpu_rd_in, cpu_wr_in, cpu_wdata_in, dma_start_in, dma_src_in,
           dma_data_in, dma_data_valid_in,
    input  ppu_data_out, ppu_data_valid_out, flag_data_out, flag_data_valid_out,
           cpu_rdata_out, cpu_rdata_valid_out, dma_addr_out, dma_rd_out, dma_busy_out, dma_done_out
  );
endinterface

// File: rtl/ppu_mem_responder.sv
// ppu_mem_responder: VRAM/OAM storage with PPU fetch and flag ports, mode-based CPU arbitration and OAM DMA
module ppu_mem_responder #(
  parameter logic [15:0] VRAM_BASE = 16'h8000,
  parameter int unsigned VRAM_SIZE = 8192,
  parameter logic [15:0] OAM_BASE  = 16'hFE00,
  parameter int unsigned OAM_SIZE  = 160,
  parameter logic [7:0]  OPEN_BUS  = 8'hFF
) (
  input logic clk_in,
  input logic rst_in,
  ppu_mem_responder_if.slave bus
);
  localparam int VW = $clog2(VRAM_SIZE);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} dma_state_e;
  dma_state_e state_q, state_d;
  logic [7:0] src_q, src_d, idx_q, idx_d;
  logic       done_q, done_d;
  logic [7:0] vram_q [0:VRAM_SIZE-1];
  logic [7:0] oam_q [0:OAM_SIZE-1];
  logic [7:0] ppu_data_q, flag_data_q, cpu_rdata_q;
  logic       ppu_valid_q, flag_valid_q, cpu_valid_q;
  logic [7:0] ppu_rd, flag_rd, cpu_rd;
  logic       busy, cpu_vram_ok, cpu_oam_ok, dma_we;
  function automatic logic in_vram(input logic [15:0] a);
    return 32'(a) >= 32'(VRAM_BASE) && 32'(a) < 32'(VRAM_BASE) + VRAM_SIZE;
  endfunction
  function automatic logic in_oam(input logic [15:0] a);
    return 32'(a) >= 32'(OAM_BASE) && 32'(a) < 32'(OAM_BASE) + OAM_SIZE;
  endfunction
  function automatic logic [VW-1:0] vram_idx(input logic [15:0] a);
    return VW'(a - VRAM_BASE);
  endfunction
  function automatic logic [7:0] oam_idx(input logic [15:0] a);
    return 8'(a - OAM_BASE);
  endfunction
  assign busy = state_q != IDLE;
  // lockouts only apply with the LCD on, except DMA which always owns OAM
  assign cpu_vram_ok = in_vram(bus.cpu_addr_in) && !(bus.lcd_en_in && bus.mode_in == 2'd3);
  assign cpu_oam_ok  = in_oam(bus.cpu_addr_in) && !(bus.lcd_en_in && bus.mode_in[1]) && !busy;
  assign dma_we      = state_q == WAIT && bus.dma_data_valid_in && !bus.dma_start_in;
  always_comb begin
    ppu_rd  = in_vram(bus.ppu_addr_in) ? vram_q[vram_idx(bus.ppu_addr_in)] :
              in_oam(bus.ppu_addr_in) ? oam_q[oam_idx(bus.ppu_addr_in)] : OPEN_BUS;
    flag_rd = in_oam(bus.flag_addr_in) ? oam_q[oam_idx(bus.flag_addr_in)] : OPEN_BUS;
    cpu_rd  = cpu_vram_ok ? vram_q[vram_idx(bus.cpu_addr_in)] :
              cpu_oam_ok ? oam_q[oam_idx(bus.cpu_addr_in)] : OPEN_BUS;
  end
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    if (bus.dma_start_in) begin
      state_d = REQ;
      src_d   = bus.dma_src_in;
      idx_d   = 8'd0;
    end else if (state_q == REQ) begin
      state_d = WAIT;
    end else if (state_q == WAIT && bus.dma_data_valid_in) begin
      state_d = idx_q == 8'(OAM_SIZE - 1) ? IDLE : REQ;
      done_d  = idx_q == 8'(OAM_SIZE - 1);
      idx_d   = idx_q == 8'(OAM_SIZE - 1) ? idx_q : idx_q + 8'd1;
    end
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      src_q        <= 8'd0;
      idx_q        <= 8'd0;
      done_q       <= 1'b0;
      ppu_data_q   <= OPEN_BUS;
      flag_data_q  <= OPEN_BUS;
      cpu_rdata_q  <= OPEN_BUS;
      ppu_valid_q  <= 1'b0;
      flag_valid_q <= 1'b0;
      cpu_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      idx_q        <= idx_d;
      done_q       <= done_d;
      ppu_valid_q  <= bus.ppu_addr_valid_in;
      flag_valid_q <= bus.flag_addr_valid_in;
      cpu_valid_q  <= bus.cpu_rd_in;
      if (bus.ppu_addr_valid_in) ppu_data_q <= ppu_rd;
      if (bus.flag_addr_valid_in) flag_data_q <= flag_rd;
      if (bus.cpu_rd_in) cpu_rdata_q <= cpu_rd;
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in && bus.cpu_wr_in && cpu_vram_ok) vram_q[vram_idx(bus.cpu_addr_in)] <= bus.cpu_wdata_in;
    if (rst_in && dma_we) oam_q[idx_q] <= bus.dma_data_in;
    else if (rst_in && bus.cpu_wr_in && cpu_oam_ok) oam_q[oam_idx(bus.cpu_addr_in)] <= bus.cpu_wdata_in;
  end
  assign bus.ppu_data_out        = ppu_data_q;
  assign bus.ppu_data_valid_out  = ppu_valid_q;
  assign bus.flag_data_out       = flag_data_q;
  assign bus.flag_data_valid_out = flag_valid_q;
  assign bus.cpu_rdata_out       = cpu_rdata_q;
  assign bus.cpu_rdata_valid_out = cpu_valid_q;
  assign bus.dma_addr_out        = {src_q, idx_q};
  assign bus.dma_rd_out          = state_q == REQ;
  assign bus.dma_busy_out        = busy;
  assign bus.dma_done_out        = done_q;
endmodule

// File: tb/tb_ppu_mem_responder.sv
// tb_ppu_mem_responder: scoreboard bench for ppu_mem_responder with an external-bus DMA responder
module tb_ppu_mem_responder;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;
  ppu_mem_responder_if b();
  ppu_mem_responder dut (.clk_in(clk_in), .rst_in(rst_in), .bus(b));
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] req_q[$];
  // external bus: answers each read request two cycles later with addr[7:0]^A5
  initial begin
    logic pv, dv;
    logic [7:0] pd, dd;
    pv = 1'b0;
    pd = 8'd0;
    b.dma_data_valid_in = 1'b0;
    b.dma_data_in = 8'd0;
    forever begin
      @(posedge clk_in);
      dv = pv;
      dd = pd;
      pv = b.dma_rd_out;
      pd = b.dma_addr_out[7:0] ^ 8'hA5;
      if (b.dma_start_in || !rst_in) begin
        dv = 1'b0;
        pv = 1'b0;
      end
      @(negedge clk_in);
      b.dma_data_valid_in = dv;
      b.dma_data_in = dd;
    end
  end
  initial forever begin
    @(posedge clk_in);
    if (b.dma_rd_out) req_q.push_back(b.dma_addr_out);
    if (b.dma_done_out) done_cnt++;
  end
  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    b.cpu_addr_in = a;
    b.cpu_wdata_in = d;
    b.cpu_wr_in = 1'b1;
    @(negedge clk_in);
    b.cpu_wr_in = 1'b0;
  endtask
  task automatic cpu_rd(input logic [15:0] a, output logic [7:0] d, output logic v, output logic vn);
    b.cpu_addr_in = a;
    b.cpu_rd_in = 1'b1;
    @(negedge clk_in);
    b.cpu_rd_in = 1'b0;
    d = b.cpu_rdata_out;
    v = b.cpu_rdata_valid_out;
    @(negedge clk_in);
    vn = b.cpu_rdata_valid_out;
  endtask
  task automatic ppu_fetch(input logic [15:0] a, output logic [7:0] d, output logic v);
    b.ppu_addr_in = a;
    b.ppu_addr_valid_in = 1'b1;
    @(negedge clk_in);
    b.ppu_addr_valid_in = 1'b0;
    d = b.ppu_data_out;
    v = b.ppu_data_valid_out;
  endtask
  task automatic flag_fetch(input logic [15:0] a, output logic [7:0] d, output logic v);
    b.flag_addr_in = a;
    b.flag_addr_valid_in = 1'b1;
    @(negedge clk_in);
    b.flag_addr_valid_in = 1'b0;
    d = b.flag_data_out;
    v = b.flag_data_valid_out;
  endtask
  task automatic dma_start(input logic [7:0] src);
    b.dma_src_in = src;
    b.dma_start_in = 1'b1;
    @(negedge clk_in);
    b.dma_start_in = 1'b0;
  endtask
  task automatic test_reset();
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    total++; if (b.ppu_data_valid_out !== 1'b0 || b.flag_data_valid_out !== 1'b0 || b.cpu_rdata_valid_out !== 1'b0) begin
      bad++; $display("FAIL reset_valids: got ppu=%b flag=%b cpu=%b want 0 0 0", b.ppu_data_valid_out, b.flag_data_valid_out, b.cpu_rdata_valid_out);
    end
    total++; if (b.ppu_data_out !== 8'hFF || b.flag_data_out !== 8'hFF || b.cpu_rdata_out !== 8'hFF) begin
      bad++; $display("FAIL reset_data: got ppu=%h flag=%h cpu=%h want ff ff ff", b.ppu_data_out, b.flag_data_out, b.cpu_rdata_out);
    end
    total++; if (b.dma_rd_out !== 1'b0 || b.dma_busy_out !== 1'b0 || b.dma_done_out !== 1'b0 || b.dma_addr_out !== 16'h0000) begin
      bad++; $display("FAIL reset_dma: got rd=%b busy=%b done=%b addr=%h want 0 0 0 0000", b.dma_rd_out, b.dma_busy_out, b.dma_done_out, b.dma_addr_out);
    end
    rst_in = 1'b1;
    @(negedge clk_in);
  endtask
  task automatic test_cpu_vram();
    logic [7:0] d, e;
    logic v, vn;
    b.mode_in = 2'd0;
    b.lcd_en_in = 1'b1;
    cpu_wr(16'h8010, 8'h5A);
    exp_q.push_back(8'h5A);
    cpu_rd(16'h8010, d, v, vn);
    e = exp_q.pop_front();
    total++; if (v !== 1'b1 || d !== e) begin bad++; $display("FAIL vram_rd: got valid=%b data=%h want 1 %h", v, d, e); end
    total++; if (vn !== 1'b0) begin bad++; $display("FAIL vram_rd_pulse: got valid=%b one cycle later want 0", vn); end
  endtask
  task automatic test_mode3_lockout();
    logic [7:0] d, e;
    logic v, vn;
    b.mode_in = 2'd3;
    cpu_wr(16'h8010, 8'h11);
    exp_q.push_back(8'hFF);
    cpu_rd(16'h8010, d, v, vn);
    e = exp_q.pop_front();
    total++; if (v !== 1'b1 || d !== e) begin bad++; $display("FAIL mode3_cpu_rd: got valid=%b data=%h want 1 %h", v, d, e); end
    exp_q.push_back(8'h5A);
    ppu_fetch(16'h8010, d, v);
    e = exp_q.pop_front();
    total++; if (v !== 1'b1 || d !== e) begin bad++; $display("FAIL mode3_ppu_fetch: got valid=%b data=%h want 1 %h", v, d, e); end
  endtask
  task automatic test_oam_lockout();
    logic [7:0] d, e;
    logic v, vn;
    b.mode_in = 2'd0;
    cpu_wr(16'hFE04, 8'h3C);
    b.mode_in = 2'd2;
    exp_q.push_back(8'hFF);
    cpu_rd(16'hFE04, d, v, vn);
    e = exp_q.pop_front();
    total++; if (v !== 1'b1 || d !== e) begin bad++; $display("FAIL mode2_oam_rd: got valid=%b data=%h want 1 %h", v, d, e); end
    b.lcd_en_in = 1'b0;
    exp_q.push_back(8'h3C);
    cpu_rd(16'hFE04, d, v, vn);
    e = exp_q.pop_front();
    total++; if (v !== 1'b1 || d !== e) begin bad++; $display("FAIL lcd_off_oam_rd: got valid=%b data=%h want 1 %h", v, d, e); end
    b.lcd_en_in = 1'b1;
    exp_q.push_back(8'h3C);
    flag_fetch(16'hFE04, d, v);
    e = exp_q.pop_front();
    total++; if (v !== 1'b1 || d !== e) begin bad++; $display("FAIL flag_oam: got valid=%b data=%h want 1 %h", v, d, e); end
    b.mode_in = 2'd0;
  endtask
  task automatic test_decode();
    logic [7:0] d, e;
    logic v, vn;
    cpu_wr(16'h9FFF, 8'hC3);
    cpu_wr(16'hFE9F, 8'h42);
    cpu_wr(16'hA000, 8'h00);
    exp_q.push_back(8'hC3);
    cpu_rd(16'h9FFF, d, v, vn);
    e = exp_q.pop_front();
    total++; if (v !== 1'b1 || d !== e) begin bad++; $display("FAIL vram_top: got valid=%b data=%h want 1 %h", v, d, e); end
    exp_q.push_back(8'hFF);
    cpu_rd(16'hA000, d, v, vn);
    e = exp_q.pop_front();
    total++; if (v !== 1'b1 || d !== e) begin bad++; $display("FAIL unmapped_a000: got valid=%b data=%h want 1 %h", v, d, e); end
    exp_q.push_back(8'hFF);
    cpu_rd(16'h7FFF, d, v, vn);
    e = exp_q.pop_front();
    total++; if (v !== 1'b1 || d !== e) begin bad++; $display("FAIL unmapped_7fff: got valid=%b data=%h want 1 %h", v, d, e); end
    exp_q.push_back(8'h42);
    ppu_fetch(16'hFE9F, d, v);
    e = exp_q.pop_front();
    total++; if (v !== 1'b1 || d !== e) begin bad++; $display("FAIL ppu_oam_last: got valid=%b data=%h want 1 %h", v, d, e); end
    exp_q.push_back(8'hFF);
    ppu_fetch(16'hFEA0, d, v);
    e = exp_q.pop_front();
    total++; if (v !== 1'b1 || d !== e) begin bad++; $display("FAIL ppu_unmapped: got valid=%b data=%h want 1 %h", v, d, e); end
    exp_q.push_back(8'h42);
    flag_fetch(16'hFE9F, d, v);
    e = exp_q.pop_front();
    total++; if (v !== 1'b1 || d !== e) begin bad++; $display("FAIL flag_oam_last: got valid=%b data=%h want 1 %h", v, d, e); end
    exp_q.push_back(8'hFF);
    flag_fetch(16'h9FFF, d, v);
    e = exp_q.pop_front();
    total++; if (v !== 1'b1 || d !== e) begin bad++; $display("FAIL flag_vram: got valid=%b data=%h want 1 %h", v, d, e); end
  endtask
  task automatic test_collision();
    logic [7:0] d, e;
    logic v, vn;
    b.mode_in = 2'd1;
    cpu_wr(16'h9800, 8'h33);
    b.cpu_addr_in = 16'h9800;
    b.cpu_wdata_in = 8'h77;
    b.cpu_wr_in = 1'b1;
    exp_q.push_back(8'h33);
    ppu_fetch(16'h9800, d, v);
    b.cpu_wr_in = 1'b0;
    e = exp_q.pop_front();
    total++; if (v !== 1'b1 || d !== e) begin bad++; $display("FAIL collide_old: got valid=%b data=%h want 1 %h", v, d, e); end
    exp_q.push_back(8'h77);
    ppu_fetch(16'h9800, d, v);
    e = exp_q.pop_front();
    total++; if (v !== 1'b1 || d !== e) begin bad++; $display("FAIL collide_new: got valid=%b data=%h want 1 %h", v, d, e); end
    cpu_wr(16'h9801, 8'h10);
    b.cpu_wdata_in = 8'h20;
    b.cpu_wr_in = 1'b1;
    exp_q.push_back(8'h10);
    cpu_rd(16'h9801, d, v, vn);
    b.cpu_wr_in = 1'b0;
    e = exp_q.pop_front();
    total++; if (v !== 1'b1 || d !== e) begin bad++; $display("FAIL rdwr_old: got valid=%b data=%h want 1 %h", v, d, e); end
    exp_q.push_back(8'h20);
    cpu_rd(16'h9801, d, v, vn);
    e = exp_q.pop_front();
    total++; if (v !== 1'b1 || d !== e) begin bad++; $display("FAIL rdwr_new: got valid=%b data=%h want 1 %h", v, d, e); end
    b.mode_in = 2'd0;
  endtask
  task automatic test_dma();
    logic [7:0] d, e;
    logic v, vn, done_seen;
    int t, busy_drop;
    req_q.delete();
    done_cnt = 0;
    busy_drop = 0;
    done_seen = 1'b0;
    dma_start(8'hC1);
    repeat (20) begin
      @(negedge clk_in);
      if (!b.dma_busy_out) busy_drop++;
    end
    exp_q.push_back(8'hFF);
    cpu_rd(16'hFE00, d, v, vn);
    e = exp_q.pop_front();
    total++; if (v !== 1'b1 || d !== e) begin bad++; $display("FAIL dma_cpu_block: got valid=%b data=%h want 1 %h", v, d, e); end
    t = 0;
    while (!done_seen && t < 2000) begin
      @(negedge clk_in);
      t++;
      if (b.dma_done_out) done_seen = 1'b1;
      else if (!b.dma_busy_out) busy_drop++;
    end
    total++; if (!done_seen) begin bad++; $display("FAIL dma_timeout: no done pulse after %0d cycles", t); end
    total++; if (busy_drop != 0) begin bad++; $display("FAIL dma_busy: got %0d idle cycles mid-transfer want 0", busy_drop); end
    repeat (5) @(negedge clk_in);
    total++; if (done_cnt != 1) begin bad++; $display("FAIL dma_done_count: got %0d want 1", done_cnt); end
    total++; if (req_q.size() != 160) begin bad++; $display("FAIL dma_req_count: got %0d want 160", req_q.size()); end
    total++; if (req_q.size() == 0 || req_q[0] !== 16'hC100 || req_q[req_q.size()-1] !== 16'hC19F) begin
      bad++; $display("FAIL dma_req_addr: got first=%h last=%h want c100 c19f", req_q.size() ? req_q[0] : 16'hxxxx, req_q.size() ? req_q[req_q.size()-1] : 16'hxxxx);
    end
    total++; if (b.dma_busy_out !== 1'b0) begin bad++; $display("FAIL dma_idle: got busy=%b want 0", b.dma_busy_out); end
  endtask
  task automatic test_back_to_back();
    logic [7:0] e;
    int errs;
    errs = 0;
    for (int k = 0; k < 160; k++) begin
      b.ppu_addr_in = 16'hFE00 + 16'(k);
      b.ppu_addr_valid_in = 1'b1;
      exp_q.push_back(8'(k) ^ 8'hA5);
      @(negedge clk_in);
      e = exp_q.pop_front();
      total++; if (b.ppu_data_valid_out !== 1'b1 || b.ppu_data_out !== e) begin
        bad++; errs++;
        if (errs < 5) $display("FAIL oam_b2b[%0d]: got valid=%b data=%h want 1 %h", k, b.ppu_data_valid_out, b.ppu_data_out, e);
      end
    end
    b.ppu_addr_valid_in = 1'b0;
    @(negedge clk_in);
  endtask
  task automatic test_restart();
    logic [7:0] d, e;
    logic v, done_seen;
    int t, n0;
    req_q.delete();
    done_cnt = 0;
    done_seen = 1'b0;
    b.lcd_en_in = 1'b0;
    cpu_wr(16'hFE32, 8'h00);
    b.lcd_en_in = 1'b1;
    dma_start(8'hC1);
    t = 0;
    while (req_q.size() < 51 && t < 1000) begin @(negedge clk_in); t++; end
    total++; if (req_q.size() < 51) begin bad++; $display("FAIL restart_wait: got %0d requests want 51", req_q.size()); end
    dma_start(8'hD0);
    n0 = req_q.size();
    t = 0;
    while (!done_seen && t < 2000) begin
      @(negedge clk_in);
      t++;
      if (b.dma_done_out) done_seen = 1'b1;
    end
    repeat (5) @(negedge clk_in);
    total++; if (done_cnt != 1) begin bad++; $display("FAIL restart_done_count: got %0d want 1", done_cnt); end
    total++; if (req_q.size() != n0 + 160 || req_q[n0] !== 16'hD000) begin
      bad++; $display("FAIL restart_req: got count=%0d first=%h want %0d d000", req_q.size() - n0, req_q.size() > n0 ? req_q[n0] : 16'hxxxx, 160);
    end
    exp_q.push_back(8'h32 ^ 8'hA5);
    ppu_fetch(16'hFE32, d, v);
    e = exp_q.pop_front();
    total++; if (v !== 1'b1 || d !== e) begin bad++; $display("FAIL restart_oam: got valid=%b data=%h want 1 %h", v, d, e); end
  endtask
  task automatic test_reset_mid_dma();
    int t;
    req_q.delete();
    dma_start(8'hC1);
    t = 0;
    while (req_q.size() < 3 && t < 500) begin @(negedge clk_in); t++; end
    total++; if (b.dma_busy_out !== 1'b1 || b.dma_rd_out !== 1'b0) begin
      bad++; $display("FAIL pre_reset_wait: got busy=%b rd=%b want 1 0", b.dma_busy_out, b.dma_rd_out);
    end
    rst_in = 1'b0;
    b.ppu_addr_in = 16'h8010;
    b.ppu_addr_valid_in = 1'b1;
    b.cpu_addr_in = 16'h8010;
    b.cpu_rd_in = 1'b1;
    @(negedge clk_in);
    b.ppu_addr_valid_in = 1'b0;
    b.cpu_rd_in = 1'b0;
    total++; if (b.dma_busy_out !== 1'b0 || b.dma_rd_out !== 1'b0 || b.dma_done_out !== 1'b0) begin
      bad++; $display("FAIL reset_mid_dma: got busy=%b rd=%b done=%b want 0 0 0", b.dma_busy_out, b.dma_rd_out, b.dma_done_out);
    end
    total++; if (b.ppu_data_valid_out !== 1'b0 || b.cpu_rdata_valid_out !== 1'b0) begin
      bad++; $display("FAIL reset_mid_valids: got ppu=%b cpu=%b want 0 0", b.ppu_data_valid_out, b.cpu_rdata_valid_out);
    end
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
  endtask
  initial begin
    b.mode_in = 2'd0;
    b.lcd_en_in = 1'b1;
    b.ppu_addr_in = 16'h0;
    b.ppu_addr_valid_in = 1'b0;
    b.flag_addr_in = 16'h0;
    b.flag_addr_valid_in = 1'b0;
    b.cpu_addr_in = 16'h0;
    b.cpu_rd_in = 1'b0;
    b.cpu_wr_in = 1'b0;
    b.cpu_wdata_in = 8'h0;
    b.dma_start_in = 1'b0;
    b.dma_src_in = 8'h0;
    @(negedge clk_in);
    test_reset();
    test_cpu_vram();
    test_mode3_lockout();
    test_oam_lockout();
    test_decode();
    test_collision();
    test_dma();
    test_back_to_back();
    test_restart();
    test_reset_mid_dma();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
